// File: rtl/alu_pkg.sv
// Shared ALU control codes, arbiter FSM encoding and op-code legalisation
// for the two-requester ALU front end.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_SLT  = 4'd11;
    localparam logic [3:0] ALU_SLTU = 4'd12;
    localparam logic [3:0] ALU_EQ   = 4'd13;
    localparam logic [3:0] ALU_NEQ  = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unassigned codes collapse to ADD so the shared ALU never sees them.
    function automatic logic [3:0] alu_legalize(input logic [3:0] op);
        logic [3:0] res;
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
            ALU_EQ, ALU_NEQ: res = op;
            default:         res = ALU_ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on contention the
// requester that was not granted last time wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant from the request vector and last-grant pointer.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_32.sv
// Shares one external combinational ALU between two requesters using an
// IDLE/EXEC/RESP sequencer with round-robin arbitration.
module alu_arbiter_32
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [OP_W-1:0]   alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    state_t            state;
    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] result_r;
    logic              owner_r;
    logic              last_r;

    logic [1:0]        grant;
    logic [OP_W-1:0]   sel_op;
    logic [OP_W-1:0]   legal_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              owner_rsp_ready;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .last  (last_r),
        .grant (grant)
    );

    // Select the granted request and legalise its op code before latching.
    always_comb begin
        if (grant[1]) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end else begin
            sel_op = req0_op;
            sel_a  = req0_a;
            sel_b  = req0_b;
        end
        // Codes wider than the 4-bit map are illegal as well.
        if ((sel_op >> 4) == '0) begin
            legal_op = OP_W'(alu_legalize(sel_op[3:0]));
        end else begin
            legal_op = OP_W'(ALU_ADD);
        end
        if (owner_r) begin
            owner_rsp_ready = rsp1_ready;
        end else begin
            owner_rsp_ready = rsp0_ready;
        end
    end

    // Sequencer: accept in IDLE, drive the ALU for one EXEC cycle, hold RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            owner_r  <= 1'b0;
            last_r   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A grant implies valid, and ready mirrors the grant here.
                    if (grant != 2'b00) begin
                        op_r    <= legal_op;
                        a_r     <= sel_a;
                        b_r     <= sel_b;
                        owner_r <= grant[1];
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_r <= alu_result;
                    last_r   <= owner_r;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner_rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake, ALU drive and response outputs decoded from the state.
    always_comb begin
        busy       = (state != ST_IDLE);
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == ST_IDLE) begin
            req0_ready = grant[0];
            req1_ready = grant[1];
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end

        if (state == ST_EXEC) begin
            alu_ctrl = op_r;
            alu_a    = a_r;
            alu_b    = b_r;
        end else begin
            alu_ctrl = '0;
            alu_a    = '0;
            alu_b    = '0;
        end

        rsp0_valid = (state == ST_RESP) && !owner_r;
        rsp1_valid = (state == ST_RESP) &&  owner_r;
        if (rsp0_valid) begin
            rsp0_data = result_r;
        end else begin
            rsp0_data = '0;
        end
        if (rsp1_valid) begin
            rsp1_data = result_r;
        end else begin
            rsp1_data = '0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter_32.sv
// Randomised and directed bench for alu_arbiter_32 with a transaction-level
// reference model and a behavioural ALU attached to the ALU port.
module tb_alu_arbiter_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter_32 #(.DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd8:    return a << sh;
            4'd9:    return a >> sh;
            4'd10:   return $unsigned($signed(a) >>> sh);
            4'd11:   return {31'd0, ($signed(a) < $signed(b))};
            4'd12:   return {31'd0, (a < b)};
            4'd13:   return {31'd0, (a == b)};
            4'd14:   return {31'd0, (a != b)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [3:0] spec_op(input logic [3:0] op);
        return (op inside {4'd5, 4'd6, 4'd7, 4'd15}) ? 4'd0 : op;
    endfunction

    assign alu_result = alu_ref(alu_ctrl, alu_a, alu_b);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference model: one outstanding op, accepted at cycle acc, ALU
    // driven the cycle after, response held from two cycles after onwards.
    bit          model_on = 1'b0;
    bit          pend = 1'b0;
    bit          own;
    bit          last_m = 1'b1;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    int          acc, cyc = 0;
    logic [1:0]  v, eg;

    always @(negedge clk) begin
        cyc++;
        if (model_on) begin
            if (!pend) begin
                v  = {req1_valid, req0_valid};
                eg = (v == 2'b11) ? (last_m ? 2'b01 : 2'b10) : v;
                check_val("m_ready0", req0_ready, eg[0]);
                check_val("m_ready1", req1_ready, eg[1]);
                check_val("m_busy_idle", busy, 0);
                check_val("m_rspv_idle", {rsp1_valid, rsp0_valid}, 0);
                check_val("m_rspd0_idle", rsp0_data, 0);
                check_val("m_rspd1_idle", rsp1_data, 0);
                check_val("m_alu_idle", {alu_ctrl, alu_a ^ alu_b, alu_a}, 0);
                if (!rst && eg != 2'b00) begin
                    pend   = 1'b1;
                    own    = eg[1];
                    m_op   = spec_op(own ? req1_op : req0_op);
                    m_a    = own ? req1_a : req0_a;
                    m_b    = own ? req1_b : req0_b;
                    m_res  = alu_ref(m_op, m_a, m_b);
                    acc    = cyc;
                    last_m = own;
                end
            end else begin
                check_val("m_ready_busy", {req1_ready, req0_ready}, 0);
                check_val("m_busy", busy, 1);
                if (cyc == acc + 1) begin
                    check_val("m_alu_ctrl", alu_ctrl, m_op);
                    check_val("m_alu_a", alu_a, m_a);
                    check_val("m_alu_b", alu_b, m_b);
                    check_val("m_rspv_exec", {rsp1_valid, rsp0_valid}, 0);
                end else begin
                    check_val("m_alu_resp", {alu_ctrl, alu_a | alu_b}, 0);
                    check_val("m_rsp0_valid", rsp0_valid, !own);
                    check_val("m_rsp1_valid", rsp1_valid, own);
                    check_val("m_rsp0_data", rsp0_data, own ? 32'd0 : m_res);
                    check_val("m_rsp1_data", rsp1_data, own ? m_res : 32'd0);
                    if (!rst && (own ? rsp1_ready : rsp0_ready)) pend = 1'b0;
                end
            end
            if (rst) begin
                pend   = 1'b0;
                last_m = 1'b1;
            end
        end
    end

    task automatic wait_accept(input bit n);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            got = n ? req1_ready : req0_ready;
            if (got) break;
        end
        check_val($sformatf("accept%0d", n), got, 1);
        @(posedge clk); #1;
        if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic issue(input bit n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (n) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        wait_accept(n);
    endtask

    task automatic get_rsp(input bit n, input logic [31:0] want, input int stall, input string tag);
        logic vld;
        vld = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vld = n ? rsp1_valid : rsp0_valid;
            if (vld) break;
        end
        check_val($sformatf("%s_valid", tag), vld, 1);
        check_val(tag, n ? rsp1_data : rsp0_data, want);
        repeat (stall) @(negedge clk);
        check_val($sformatf("%s_hold", tag), n ? rsp1_data : rsp0_data, want);
        @(posedge clk); #1;
        if (n) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(posedge clk); #1;
        if (n) rsp1_ready = 1'b0; else rsp0_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_op = 4'd0; req1_op = 4'd0;
        req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
        repeat (2) @(posedge clk);
        #1 model_on = 1'b1;
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", {req1_ready, req0_ready}, 0);
        check_val("rst_rspv", {rsp1_valid, rsp0_valid}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single ADD with exact latency.
        rsp0_ready = 1'b1;
        issue(0, 4'd0, 32'd5, 32'd7);
        @(negedge clk);
        check_val("add_exec_ctrl", alu_ctrl, 0);
        check_val("add_exec_a", alu_a, 5);
        @(negedge clk);
        check_val("add_rsp_valid", rsp0_valid, 1);
        check_val("add_rsp_data", rsp0_data, 12);
        @(posedge clk); #1 rsp0_ready = 1'b0;

        // Contention from reset pointer: grants alternate starting with 0.
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd0; req0_valid = 1'b1;
        req1_op = 4'd0; req1_a = 32'd2; req1_b = 32'd0; req1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            logic [1:0] gv;
            gv = 2'b00;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                gv = {req1_ready, req0_ready};
                if (gv != 2'b00) break;
            end
            check_val($sformatf("rr_grant%0d", g), gv, (g % 2 == 1) ? 2'b10 : 2'b01);
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(posedge clk); #1 rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // SUB with a stalled response while req0 waits.
        issue(1, 4'd1, 32'd3, 32'd5);
        req0_op = 4'd0; req0_a = 32'd9; req0_b = 32'd9; req0_valid = 1'b1;
        get_rsp(1, 32'hFFFF_FFFE, 4, "sub_stall");
        wait_accept(0);
        get_rsp(0, 32'd18, 0, "after_stall");

        // Illegal code 6 becomes ADD.
        issue(0, 4'd6, 32'd2, 32'd2);
        @(negedge clk);
        check_val("illegal_ctrl", alu_ctrl, 0);
        get_rsp(0, 32'd4, 0, "illegal_op");

        // Arithmetic shift right.
        issue(0, 4'd10, 32'h8000_0000, 32'd4);
        @(negedge clk);
        check_val("sra_ctrl", alu_ctrl, 10);
        get_rsp(0, 32'hF800_0000, 1, "sra");

        // Reset while in RESP discards the pending response.
        issue(0, 4'd0, 32'd1, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp0_valid) break;
        end
        check_val("pre_rst_rspv", rsp0_valid, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; rsp0_ready = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_rspv", {rsp1_valid, rsp0_valid}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("no_late_rsp", rsp0_valid, 0);
        end

        // Randomised traffic, occasional resets; the model checks every cycle.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            rst        = ($urandom_range(0, 299) == 0);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op    = 4'($urandom);
            req1_op    = 4'($urandom);
            req0_a     = ($urandom_range(0, 3) == 0) ? (32'h8000_0000 | $urandom) : $urandom;
            req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req1_a     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            req1_b     = ($urandom_range(0, 3) == 0) ? 32'(($urandom_range(0, 40))) : $urandom;
            rsp0_ready = ($urandom_range(0, 1) == 1);
            rsp1_ready = ($urandom_range(0, 1) == 1);
        end
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_val("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
